uart_iob_core: RTL and testbench
================================

Name: uart_iob_core

Overview:
- RS232 UART peripheral with an IOb-native slave register interface; 8N1 framing and RTS/CTS hardware flow control.
- Used as a SoC peripheral and as a testbench-side UART cross-wired to a SoC UART (txd↔rxd, rts↔cts).
- CPU/host programs the baud divider, enables TX/RX, writes bytes to send, and polls/reads received bytes.

Parameters:
- DATA_W, 32, IOb data bus width; must be 32.
- ADDR_W, 3, IOb byte address width of the register map.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- arst_n_i  in  1  reset; asynchronous assert, active-low.
- cke_i  in  1  clock enable; when 0, all state holds.
- iob_avalid_i  in  1  request valid.
- iob_addr_i  in  ADDR_W  byte address.
- iob_wdata_i  in  DATA_W  write data, byte-lane aligned to address.
- iob_wstrb_i  in  DATA_W/8  write strobes; 0 means read.
- iob_rdata_o  out  DATA_W  read data.
- iob_rvalid_o  out  1  read data valid.
- iob_ready_o  out  1  request accepted.
- txd  out  1  serial transmit; idles high.
- rxd  in  1  serial receive.
- rts  out  1  ready-to-send; high when the receiver is enabled.
- cts  in  1  clear-to-send from the peer; gates transmit start.

Behaviour:
- Reset: txd=1, rts=0, iob_rvalid_o=0, iob_rdata_o=0, iob_ready_o=1, DIV=0, TXEN=0, RXEN=0, rx_ready=0, tx FSM idle.
- iob_ready_o is tied to 1: every request is accepted in the cycle avalid is high.
- Write registers:
  - addr 0 SOFTRESET (1b, byte 0): a write of 1 resets TX/RX FSMs, rx_ready, TXEN, RXEN; DIV is kept.
  - addr 2 DIV (16b, bytes 2-3): clock cycles per bit.
  - addr 4 TXDATA (8b, byte 0): the write starts a frame.
  - addr 5 TXEN (1b, byte 1).
  - addr 6 RXEN (1b, byte 2).
- Write lane rule: a register updates only if avalid is high and the wstrb bits covering its byte lanes are set.
- Read registers (wstrb==0):
  - addr 0 TXREADY: bit0 = TXEN & tx idle.
  - addr 1 RXREADY: bit8 = rx_ready.
  - addr 4 RXDATA: bits7:0 = last received byte.
  - Unmapped read addresses return 0.
- Read latency: iob_rdata_o and iob_rvalid_o are registered one cycle after the request; rvalid pulses for exactly one cycle per read. Writes produce no rvalid.
- Reading RXDATA clears rx_ready in the same cycle the read is accepted.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a TXDATA write when TXEN=1, the FSM is IDLE and cts=1. The byte is latched.
  - If cts=0, the write is held pending and starts when cts rises. The pending flag clears on softreset.
  - Each bit lasts DIV cycles; data goes out LSB first; then one stop bit (1); then back to IDLE.
  - A TXDATA write while busy is ignored.
  - With DIV<2, the divider behaves as 2.
- RX FSM, active only when RXEN=1:
  - rxd passes through a 2-flop synchronizer.
  - A falling edge starts a frame; the line is sampled at mid-bit (DIV/2), then every DIV cycles.
  - If the start bit samples high, the event is a glitch and the FSM returns to idle.
  - The 8 data bits are captured LSB first; the stop bit is sampled.
  - On frame completion, RXDATA is updated and rx_ready=1 regardless of the stop value. Overrun overwrites RXDATA.
- rts = RXEN.
- Reset asserted mid-frame: txd returns to 1 immediately (asynchronous), and the frame is aborted.
- cke_i=0: FSMs, counters and registers freeze; outputs hold.

Decomposition:
- Shared package: register address constants (SOFTRESET=0, DIV=2, TXDATA=4, TXEN=5, RXEN=6, TXREADY=0, RXREADY=1, RXDATA=4), register widths, FSM state encodings.
- One sub-module, uart_iob_core_regs: IOb decode, write registers, read mux and rvalid. TX/RX FSMs stay in the top module.

Test Plan:
- Reset then read addr 0 → rvalid one cycle later, rdata=0; txd=1, rts=0.
- Write DIV=16 (addr 2, wstrb 4'b1100), TXEN=1, then TXDATA=0x55 with cts=1 → txd: start 0 for 16 cycles, then bits 1,0,1,0,1,0,1,0 (LSB first), stop 1. TXREADY=0 during the frame, 1 after 160 cycles.
- Loopback two instances, both DIV=16 and RXEN=1, TX 0xA3 → receiver RXREADY bit8=1; read RXDATA returns 0xA3; RXREADY then 0.
- cts=0 and TXDATA=0x0F written → txd stays 1; raise cts → frame starts within 1 cycle.
- Mid-frame softreset write (addr 0, data 1) → txd=1 next cycle, TXEN=0, DIV still 16.
- 1-cycle low glitch on rxd with RXEN=1 → no rx_ready; hold cke_i=0 mid-frame for 50 cycles → frame resumes unaltered.

Source files
------------

// File: rtl/uart_iob_core_pkg.sv
// Shared constants for the IOb UART: register map, field widths, FSM encodings.
package uart_iob_core_pkg;

  localparam int DIV_W  = 16;
  localparam int BYTE_W = 8;

  localparam logic [2:0] ADDR_SOFTRESET = 3'd0;
  localparam logic [2:0] ADDR_DIV       = 3'd2;
  localparam logic [2:0] ADDR_TXDATA    = 3'd4;
  localparam logic [2:0] ADDR_TXEN      = 3'd5;
  localparam logic [2:0] ADDR_RXEN      = 3'd6;
  localparam logic [2:0] ADDR_TXREADY   = 3'd0;
  localparam logic [2:0] ADDR_RXREADY   = 3'd1;
  localparam logic [2:0] ADDR_RXDATA    = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             txen;
    logic             rxen;
  } cfg_t;

  // A divider below 2 would leave no room for a mid-bit sample point.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_iob_core_if.sv
// IOb-native request/response bundle between a host and the UART register file.
interface uart_iob_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic                iob_avalid_i;
  logic [ADDR_W-1:0]   iob_addr_i;
  logic [DATA_W-1:0]   iob_wdata_i;
  logic [DATA_W/8-1:0] iob_wstrb_i;
  logic [DATA_W-1:0]   iob_rdata_o;
  logic                iob_rvalid_o;
  logic                iob_ready_o;

  modport master (
    output iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_rdata_o, iob_rvalid_o, iob_ready_o
  );

  modport slave (
    input  iob_avalid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_rdata_o, iob_rvalid_o, iob_ready_o
  );
endinterface

// File: rtl/uart_iob_core_regs.sv
// Register file: IOb decode, config registers, command pulses and registered read mux.
module uart_iob_core_regs import uart_iob_core_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  uart_iob_core_if.slave    iob,
  input  logic              tx_idle,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  output cfg_t              cfg,
  output logic              soft_rst,
  output logic              tx_wr,
  output logic [BYTE_W-1:0] tx_wr_data,
  output logic              rx_rd
);

  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_mux;
  logic              wr, rd, word1;
  logic              div_we, txen_we, rxen_we;
  logic              unused_wdata;

  assign addr  = iob.iob_addr_i;
  assign wstrb = iob.iob_wstrb_i;
  assign wdata = iob.iob_wdata_i;
  assign wr    = iob.iob_avalid_i & (|wstrb);
  assign rd    = iob.iob_avalid_i & ~(|wstrb);
  assign word1 = addr[2];

  // Writes select the 32-bit word, then each register needs its own lanes strobed.
  assign soft_rst   = wr & (word1 == ADDR_SOFTRESET[2]) & wstrb[0] & wdata[0];
  assign div_we     = wr & (word1 == ADDR_DIV[2]) & wstrb[3] & wstrb[2];
  assign tx_wr      = wr & (word1 == ADDR_TXDATA[2]) & wstrb[0];
  assign txen_we    = wr & (word1 == ADDR_TXEN[2]) & wstrb[1];
  assign rxen_we    = wr & (word1 == ADDR_RXEN[2]) & wstrb[2];
  assign tx_wr_data = wdata[7:0];
  assign rx_rd      = rd & (addr == ADDR_RXDATA);

  assign iob.iob_ready_o = 1'b1;
  assign unused_wdata    = ^wdata[15:9];

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_TXREADY: rd_mux[0]   = cfg.txen & tx_idle;
      ADDR_RXREADY: rd_mux[8]   = rx_ready;
      ADDR_RXDATA:  rd_mux[7:0] = rx_data;
      default:      rd_mux      = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cfg              <= '0;
      iob.iob_rdata_o  <= '0;
      iob.iob_rvalid_o <= 1'b0;
    end else if (cke_i) begin
      iob.iob_rvalid_o <= rd;
      if (rd)
        iob.iob_rdata_o <= rd_mux;
      if (div_we)
        cfg.div <= wdata[31:16];
      if (soft_rst) begin
        cfg.txen <= 1'b0;
        cfg.rxen <= 1'b0;
      end else begin
        if (txen_we) cfg.txen <= wdata[8];
        if (rxen_we) cfg.rxen <= wdata[16];
      end
    end
  end

endmodule

// File: rtl/uart_iob_core.sv
// 8N1 UART with RTS/CTS flow control behind an IOb register interface.
//   state    | meaning
//   ST_IDLE  | line idle (txd=1) / waiting for a falling edge on rxd
//   ST_START | start bit: driving 0 / waiting for the mid-start sample
//   ST_DATA  | 8 data bits, LSB first
//   ST_STOP  | stop bit: driving 1 / waiting for the stop sample
module uart_iob_core import uart_iob_core_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  input  logic           cke_i,
  uart_iob_core_if.slave iob,
  output logic           txd,
  input  logic           rxd,
  output logic           rts,
  input  logic           cts
);

  cfg_t              cfg;
  logic              soft_rst, tx_wr, rx_rd, tx_idle, tx_req;
  logic [BYTE_W-1:0] tx_wr_data;
  logic [DIV_W-1:0]  div_eff;

  logic [1:0]        tx_state;
  logic [DIV_W-1:0]  tx_cnt;
  logic [BYTE_W-1:0] tx_sh;
  logic [2:0]        tx_bit;
  logic              tx_pend;

  logic [1:0]        rx_state;
  logic [DIV_W-1:0]  rx_cnt;
  logic [BYTE_W-1:0] rx_sh, rx_data;
  logic [2:0]        rx_bit;
  logic              rx_ready, rx_s1, rx_s2, rx_s3;

  uart_iob_core_regs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regs (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .cke_i      (cke_i),
    .iob        (iob),
    .tx_idle    (tx_idle),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .cfg        (cfg),
    .soft_rst   (soft_rst),
    .tx_wr      (tx_wr),
    .tx_wr_data (tx_wr_data),
    .rx_rd      (rx_rd)
  );

  assign div_eff = eff_div(cfg.div);
  assign tx_idle = (tx_state == ST_IDLE) & ~tx_pend;
  assign tx_req  = tx_wr & cfg.txen & ~tx_pend;
  assign rts     = cfg.rxen;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      tx_bit   <= '0;
      tx_pend  <= 1'b0;
      txd      <= 1'b1;
    end else if (cke_i) begin
      if (soft_rst) begin
        tx_state <= ST_IDLE;
        tx_cnt   <= '0;
        tx_pend  <= 1'b0;
        txd      <= 1'b1;
      end else begin
        case (tx_state)
          ST_IDLE: begin
            if (tx_req)
              tx_sh <= tx_wr_data;
            // A byte written while cts is low waits here until the peer is ready.
            if ((tx_req | tx_pend) & cts) begin
              tx_pend  <= 1'b0;
              tx_state <= ST_START;
              tx_cnt   <= div_eff - 16'd1;
              txd      <= 1'b0;
            end else if (tx_req) begin
              tx_pend <= 1'b1;
            end
          end
          ST_START: begin
            if (tx_cnt == '0) begin
              tx_state <= ST_DATA;
              tx_cnt   <= div_eff - 16'd1;
              tx_bit   <= '0;
              txd      <= tx_sh[0];
              tx_sh    <= tx_sh >> 1;
            end else begin
              tx_cnt <= tx_cnt - 16'd1;
            end
          end
          ST_DATA: begin
            if (tx_cnt == '0) begin
              tx_cnt <= div_eff - 16'd1;
              if (tx_bit == 3'd7) begin
                tx_state <= ST_STOP;
                txd      <= 1'b1;
              end else begin
                tx_bit <= tx_bit + 3'd1;
                txd    <= tx_sh[0];
                tx_sh  <= tx_sh >> 1;
              end
            end else begin
              tx_cnt <= tx_cnt - 16'd1;
            end
          end
          default: begin
            if (tx_cnt == '0)
              tx_state <= ST_IDLE;
            else
              tx_cnt <= tx_cnt - 16'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
    end else if (cke_i) begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      // A completing frame in the same cycle as an RXDATA read keeps rx_ready set.
      if (rx_rd)
        rx_ready <= 1'b0;
      if (soft_rst) begin
        rx_state <= ST_IDLE;
        rx_ready <= 1'b0;
      end else if (!cfg.rxen) begin
        rx_state <= ST_IDLE;
      end else begin
        case (rx_state)
          ST_IDLE: begin
            if (rx_s3 & ~rx_s2) begin
              rx_state <= ST_START;
              rx_cnt   <= (div_eff >> 1) - 16'd1;
            end
          end
          ST_START: begin
            if (rx_cnt == '0) begin
              if (!rx_s2) begin
                rx_state <= ST_DATA;
                rx_cnt   <= div_eff - 16'd1;
                rx_bit   <= '0;
              end else begin
                rx_state <= ST_IDLE;
              end
            end else begin
              rx_cnt <= rx_cnt - 16'd1;
            end
          end
          ST_DATA: begin
            if (rx_cnt == '0) begin
              rx_sh  <= {rx_s2, rx_sh[7:1]};
              rx_cnt <= div_eff - 16'd1;
              if (rx_bit == 3'd7)
                rx_state <= ST_STOP;
              else
                rx_bit <= rx_bit + 3'd1;
            end else begin
              rx_cnt <= rx_cnt - 16'd1;
            end
          end
          default: begin
            if (rx_cnt == '0) begin
              rx_data  <= rx_sh;
              rx_ready <= 1'b1;
              rx_state <= ST_IDLE;
            end else begin
              rx_cnt <= rx_cnt - 16'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_iob_core.sv
// Two cross-wired UARTs: dut0 transmits, dut1 receives; txd is checked against an 8N1 frame model.
module tb_uart_iob_core;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cke = 1'b1;
  logic cts_drv = 1'b1;
  logic glitch_n = 1'b1;
  logic txd0, txd1, rts0, rts1, rxd1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  uart_iob_core_if #(.DATA_W(32), .ADDR_W(3)) if0 ();
  uart_iob_core_if #(.DATA_W(32), .ADDR_W(3)) if1 ();

  assign rxd1 = txd0 & glitch_n;

  uart_iob_core #(.DATA_W(32), .ADDR_W(3)) dut0 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .iob(if0.slave),
    .txd(txd0), .rxd(txd1), .rts(rts0), .cts(cts_drv)
  );

  uart_iob_core #(.DATA_W(32), .ADDR_W(3)) dut1 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .iob(if1.slave),
    .txd(txd1), .rxd(rxd1), .rts(rts1), .cts(rts0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // 8N1 frame: position 0 start, 1..8 data LSB first, 9 stop
  function automatic logic model_bit(input int b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return ((b >> (idx - 1)) & 1) != 0;
  endfunction

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic bus_drive(input int which, input logic v, input logic [2:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    if (which == 0) begin
      if0.iob_avalid_i = v; if0.iob_addr_i = a; if0.iob_wdata_i = d; if0.iob_wstrb_i = s;
    end else begin
      if1.iob_avalid_i = v; if1.iob_addr_i = a; if1.iob_wdata_i = d; if1.iob_wstrb_i = s;
    end
  endtask

  task automatic wr(input int which, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); bus_drive(which, 1'b1, a, d, s);
    @(negedge clk); bus_drive(which, 1'b0, 3'd0, 32'd0, 4'd0);
  endtask

  task automatic rd(input int which, input logic [2:0] a, output logic [31:0] d, output logic v);
    @(negedge clk); bus_drive(which, 1'b1, a, 32'd0, 4'd0);
    @(negedge clk); bus_drive(which, 1'b0, 3'd0, 32'd0, 4'd0);
    if (which == 0) begin d = if0.iob_rdata_o; v = if0.iob_rvalid_o; end
    else begin d = if1.iob_rdata_o; v = if1.iob_rvalid_o; end
  endtask

  // Sends byte b from dut0 and follows txd; k counts only clock edges with cke high.
  task automatic tx_frame(input int b, input int d, input bit every_cycle, input int freeze_at);
    int e, k, it;
    e = eff(d); k = 0; it = 0;
    wr(0, 3'd4, b, 4'b0001);
    while (k < 10 * e && it < 20 * e + 200) begin
      if (every_cycle || (k % e == e / 2))
        chk($sformatf("txd_b%0h_k%0d", b, k), txd0, model_bit(b, k / e));
      if (freeze_at > 0 && it == freeze_at) cke = 1'b0;
      if (freeze_at > 0 && it == freeze_at + 50) cke = 1'b1;
      @(negedge clk);
      it++;
      if (cke) k++;
    end
    if (k < 10 * e) chk("tx_frame_timeout", k, 10 * e);
  endtask

  task automatic rx_expect(input int which, input int b, input string tag);
    logic [31:0] d;
    logic v;
    int n;
    n = 0;
    do begin
      rd(which, 3'd1, d, v);
      n++;
    end while (d[8] !== 1'b1 && n < 500);
    chk({tag, "_rxready"}, d[8], 1);
    rd(which, 3'd4, d, v);
    chk({tag, "_rxdata"}, d, b & 8'hff);
    rd(which, 3'd1, d, v);
    chk({tag, "_rxready_clr"}, d[8], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic v;
    int dv, b;
    bus_drive(0, 1'b0, 3'd0, 32'd0, 4'd0);
    bus_drive(1, 1'b0, 3'd0, 32'd0, 4'd0);
    repeat (3) @(negedge clk);
    chk("rst_txd", txd0, 1);
    chk("rst_rts", rts0, 0);
    chk("rst_rvalid", if0.iob_rvalid_o, 0);
    chk("rst_rdata", if0.iob_rdata_o, 0);
    arst_n = 1'b1;
    chk("ready", if0.iob_ready_o, 1);

    rd(0, 3'd0, d, v);
    chk("rst_rd_rvalid", v, 1);
    chk("rst_rd_txready", d, 0);
    @(negedge clk);
    chk("rvalid_one_pulse", if0.iob_rvalid_o, 0);

    // TXEN lives in lane 1: a lane-0 strobe must not set it
    wr(0, 3'd5, 32'h100, 4'b0001);
    chk("wr_no_rvalid", if0.iob_rvalid_o, 0);
    rd(0, 3'd0, d, v);
    chk("txen_wrong_lane", d, 0);
    wr(0, 3'd5, 32'h100, 4'b0010);
    rd(0, 3'd0, d, v);
    chk("txen_set_txready", d, 1);

    wr(0, 3'd2, 32'd16 << 16, 4'b1100);
    wr(1, 3'd2, 32'd16 << 16, 4'b1100);
    wr(1, 3'd6, 32'h1_0000, 4'b0100);
    wr(0, 3'd6, 32'h1_0000, 4'b0100);
    chk("rts1_rxen", rts1, 1);
    chk("rts0_rxen", rts0, 1);

    fork
      tx_frame(8'h55, 16, 1'b1, 0);
      begin
        logic [31:0] dd;
        logic vv;
        repeat (20) @(negedge clk);
        rd(0, 3'd0, dd, vv);
        chk("txready_busy", dd, 0);
      end
    join
    rd(0, 3'd0, d, v);
    chk("txready_after", d, 1);
    rx_expect(1, 8'h55, "rx55");

    tx_frame(8'hA3, 16, 1'b0, 0);
    rx_expect(1, 8'hA3, "loopA3");

    cts_drv = 1'b0;
    wr(0, 3'd4, 32'h0F, 4'b0001);
    for (int i = 0; i < 30; i++) begin
      chk("cts_low_idle", txd0, 1);
      @(negedge clk);
    end
    cts_drv = 1'b1;
    @(negedge clk);
    chk("cts_rise_start", txd0, 0);
    repeat (170) @(negedge clk);
    rx_expect(1, 8'h0F, "cts0F");

    @(negedge clk); glitch_n = 1'b0;
    @(negedge clk); glitch_n = 1'b1;
    repeat (40) @(negedge clk);
    rd(1, 3'd1, d, v);
    chk("glitch_no_rx", d[8], 0);

    tx_frame(8'hC6, 16, 1'b1, 50);
    rx_expect(1, 8'hC6, "ckeC6");

    wr(1, 3'd6, 32'h0, 4'b0100);
    wr(0, 3'd4, 32'h00, 4'b0001);
    repeat (40) @(negedge clk);
    chk("pre_softrst_low", txd0, 0);
    wr(0, 3'd0, 32'h1, 4'b0001);
    chk("softrst_txd", txd0, 1);
    rd(0, 3'd0, d, v);
    chk("softrst_txen", d, 0);
    wr(0, 3'd4, 32'h00, 4'b0001);
    repeat (5) @(negedge clk);
    chk("txen0_write_ignored", txd0, 1);
    wr(0, 3'd5, 32'h100, 4'b0010);
    wr(1, 3'd6, 32'h1_0000, 4'b0100);
    tx_frame(8'h5A, 16, 1'b1, 0);
    rx_expect(1, 8'h5A, "div_kept");

    for (int n = 0; n < 12; n++) begin
      dv = $urandom_range(24, 0);
      b  = $urandom_range(255, 0);
      wr(0, 3'd2, dv << 16, 4'b1100);
      wr(1, 3'd2, dv << 16, 4'b1100);
      tx_frame(b, dv, 1'b0, 0);
      rx_expect(1, b, $sformatf("rnd%0d_div%0d", n, dv));
    end

    wr(0, 3'd2, 32'd16 << 16, 4'b1100);
    wr(0, 3'd4, 32'h00, 4'b0001);
    repeat (20) @(negedge clk);
    chk("pre_arst_low", txd0, 0);
    #2 arst_n = 1'b0;
    #1 chk("async_rst_txd", txd0, 1);
    @(negedge clk);
    arst_n = 1'b1;
    rd(0, 3'd0, d, v);
    chk("arst_txready", d, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
